// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM state types
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_PARITY,
        T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP
    } rx_state_t;

    // Payload is zero-extended to 9 bits; padding zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts while run is high and pulses tick once per bit
// period, or once per half period while half is high.
module uart_bit_timer #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic half,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLK_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == (half ? HALF_TERM : FULL_TERM));

    // NOTE: sequential state uses non-blocking <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with configurable data width, parity and stop bits.
// Optional macro UART_BREAK_DET_EN adds rx_break and suppresses break frames.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 tx_data_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out
`ifdef UART_BREAK_DET_EN
    ,
    output logic                 rx_break
`endif
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_next;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic [BC_W-1:0]      tx_bit_cnt;
    logic                 tx_tick;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
        .clk   (clk),
        .reset (reset),
        .run   (tx_state != T_IDLE),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) tx_state <= T_IDLE;
        else       tx_state <= tx_next;
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:   if (tx_data_valid) tx_next = T_START;
            T_START:  if (tx_tick) tx_next = T_DATA;
            T_DATA:   if (tx_tick && tx_bit_cnt == LAST_DATA) tx_next = HAS_PAR ? T_PARITY : T_STOP;
            T_PARITY: if (tx_tick) tx_next = T_STOP;
            T_STOP:   if (tx_tick && tx_bit_cnt == LAST_STOP) tx_next = T_IDLE;
            default:  tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state == T_IDLE);
        case (tx_state)
            T_START:  tx_out = 1'b0;
            T_DATA:   tx_out = tx_shreg[0];
            T_PARITY: tx_out = tx_par;
            default:  tx_out = 1'b1;
        endcase
    end

    // The bit counter indexes data bits, then is reused to count stop bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shreg   <= '0;
            tx_par     <= 1'b0;
            tx_bit_cnt <= '0;
        end else begin
            case (tx_state)
                T_IDLE: if (tx_data_valid) begin
                    tx_shreg   <= tx_data;
                    tx_par     <= parity_bit(9'(tx_data), PARITY);
                    tx_bit_cnt <= '0;
                end
                T_DATA: if (tx_tick) begin
                    tx_shreg   <= tx_shreg >> 1;
                    tx_bit_cnt <= (tx_bit_cnt == LAST_DATA) ? '0 : tx_bit_cnt + 1'b1;
                end
                T_STOP: if (tx_tick) tx_bit_cnt <= tx_bit_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state, rx_next;
    logic                 rx_meta, rx_s;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par_s;
    logic [BC_W-1:0]      rx_bit_cnt;
    logic                 rx_tick;
    logic                 rx_done;
    logic                 rx_brk_hold;
    logic                 rx_brk_frame;

    // Synchroniser flops reset to the idle-high line level to avoid a false start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
        .clk   (clk),
        .reset (reset),
        .run   (rx_state != R_IDLE),
        .half  (rx_state == R_START),
        .tick  (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) rx_state <= R_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:   if (!rx_s && !rx_brk_hold) rx_next = R_START;
            R_START:  if (rx_tick) rx_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:   if (rx_tick && rx_bit_cnt == LAST_DATA) rx_next = HAS_PAR ? R_PARITY : R_STOP;
            R_PARITY: if (rx_tick) rx_next = R_STOP;
            R_STOP:   if (rx_tick) rx_next = R_IDLE;
            default:  rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        rx_done = (rx_state == R_STOP) && rx_tick;
    end

`ifdef UART_BREAK_DET_EN
    logic rx_is_break;
    assign rx_is_break  = (rx_shreg == '0) && !(HAS_PAR && rx_par_s) && !rx_s;
    assign rx_brk_frame = rx_done && rx_is_break;

    // After a break the line must return high before another start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_break    <= 1'b0;
            rx_brk_hold <= 1'b0;
        end else begin
            rx_break <= rx_brk_frame;
            if (rx_brk_frame) rx_brk_hold <= 1'b1;
            else if (rx_s)    rx_brk_hold <= 1'b0;
        end
    end
`else
    assign rx_brk_hold  = 1'b0;
    assign rx_brk_frame = 1'b0;
`endif

    // NOTE: the payload and status registers are reset too, so rx_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shreg      <= '0;
            rx_par_s      <= 1'b0;
            rx_bit_cnt    <= '0;
            rx_data_valid <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            case (rx_state)
                R_START:  if (rx_tick) rx_bit_cnt <= '0;
                R_DATA:   if (rx_tick) begin
                    rx_shreg   <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                    rx_bit_cnt <= rx_bit_cnt + 1'b1;
                end
                R_PARITY: if (rx_tick) rx_par_s <= rx_s;
                default: ;
            endcase
            if (rx_done && !rx_brk_frame) begin
                rx_data_valid <= 1'b1;
                rx_data       <= rx_shreg;
                rx_frame_err  <= !rx_s;
                rx_parity_err <= HAS_PAR && (rx_par_s != parity_bit(9'(rx_shreg), PARITY));
            end
        end
    end

endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
Parametrised full-duplex UART transceiver and successor to the fixed 8N1 UART.
- Configurable data width, parity and stop-bit count.
- Divisor-based bit timing; receive samples at mid-bit and rejects start-bit glitches.
- Reports framing and parity errors.
- Sits between the host-link byte stream logic and the board RX/TX pins.

Parameters:
CLK_DIV, 434, clock cycles per bit period (>=4); 100 MHz / 230400 baud.
DATA_BITS, 8, payload bits per frame, 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits transmitted, 1 or 2. Receiver checks only the first.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_in  in  1  serial input, asynchronous to clk
rx_data_valid  out  1  one-cycle pulse when a frame completes
rx_data  out  DATA_BITS  last received payload; held until the next pulse
rx_frame_err  out  1  qualified by rx_data_valid; first stop bit sampled low
rx_parity_err  out  1  qualified by rx_data_valid; parity mismatch (0 when PARITY=0)
tx_data_valid  in  1  request to send tx_data
tx_data  in  DATA_BITS  payload; sampled only on acceptance
tx_ready  out  1  high in TX idle
tx_out  out  1  serial output, idle high

Behaviour:
- Reset is synchronous on clk. All state returns to idle, even mid-frame.
- Reset values: tx_out=1, tx_ready=1, rx_data_valid=0, rx_data=0, both error flags=0.
- Frame layout, LSB first: start(0), DATA_BITS data, parity bit if PARITY!=0, STOP_BITS x 1.
- Parity computation: odd parity bit = ~^data; even parity bit = ^data.
- Let NBITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- TX FSM states: T_IDLE, T_START, T_DATA, T_PARITY, T_STOP.
  - Acceptance: tx_data_valid & tx_ready in T_IDLE; tx_data is latched on that edge.
  - On the following cycle tx_out=0 and tx_ready=0.
  - Each bit is held exactly CLK_DIV cycles. tx_ready stays low for NBITS*CLK_DIV cycles, then returns to 1.
  - With tx_data_valid held high, the next acceptance happens on the first cycle tx_ready=1. This gives exactly one idle-high cycle between frames.
  - tx_data_valid while busy is ignored; there is no queueing.
- RX input: rx_in passes through a 2-flop synchroniser (rx_s). Everything below uses rx_s.
- RX FSM states: R_IDLE, R_START, R_DATA, R_PARITY, R_STOP.
  - R_IDLE: move to R_START when rx_s=0.
  - R_START: after CLK_DIV/2 cycles, sample rx_s. If 1, it was a glitch: back to R_IDLE with no pulse and no flags. If 0, the start bit is confirmed.
  - Later bits: each is sampled CLK_DIV cycles after the previous sample (mid-bit). Data is shifted LSB first.
  - Stop bit: at the stop-bit sample, rx_data_valid=1 for exactly 1 cycle on the next edge. rx_data and both error flags update on that same cycle.
  - After the stop-bit sample the FSM returns straight to R_IDLE. A new start bit is therefore detected at the first low after the stop sample, tolerating up to a half-bit of clock skew.
  - A frame with a framing error is still delivered, with rx_frame_err=1.
- Bit counter: width $clog2(DATA_BITS+1). Bit-timer counter: width $clog2(CLK_DIV). The bit timer wraps to 0 on reaching CLK_DIV-1.
- TX and RX are fully independent. Simultaneous TX acceptance and RX completion have no interaction.

Optional Feature:
Macro UART_BREAK_DET_EN.
- Defined: adds output rx_break (1 bit, reset 0). It pulses for 1 cycle when a frame has all-zero data, a parity bit of 0 (if present) and a stop bit of 0.
  - In that case rx_data_valid is suppressed.
  - The receiver then waits for rx_s=1 before leaving R_IDLE-hold. This prevents repeated frames during a long break.
- Undefined: no rx_break port. Such a frame is delivered as data 0 with rx_frame_err=1.

Decomposition:
- Package uart_pkg holds:
  - parity localparams PAR_NONE / PAR_ODD / PAR_EVEN;
  - the TX and RX state typedefs;
  - function parity_bit(data, mode).
- One sub-module, uart_bit_timer (params CLK_DIV; ports clk, reset, run, half, tick), instantiated once for TX and once for RX.
  - run=0 clears the count.
  - tick is a 1-cycle pulse at full period, or at half period when half=1.

Test Plan (CLK_DIV=8 unless stated):
- 8N1, send 0xA5 -> tx_out shows 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. tx_ready low for 80 cycles. Loop tx_out back into rx_in -> rx_data=0xA5, one valid pulse, no flags.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, send 0x55 -> parity bit 0, tx_ready low for 88 cycles. Same frame with the parity bit flipped on the RX side -> rx_parity_err=1 with valid.
- RX start glitch: rx_in low for 3 cycles, then high -> no rx_data_valid, RX back in idle. A following clean 0x3C frame is received correctly.
- RX stop bit forced low on a 0x81 frame -> rx_data=0x81, rx_frame_err=1. With UART_BREAK_DET_EN and a 10-bit-time low -> single rx_break pulse and no rx_data_valid.
- Back-to-back TX of 0x11, then 0x22 with valid held -> exactly one idle-high cycle between frames. Assert reset mid-frame -> tx_out=1 and tx_ready=1 on the next cycle.
- CLK_DIV=5 (odd): RX of 0xF0 sampling at cycles 2, 7, 12, ... relative to the detected start -> correct data.
